ds1302_ctrl: RTL and testbench

//  Sequencer for the single-byte DS1302 serial driver. After reset it clears write-protect,

---
 rtl/ds1302_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ds1302_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_ctrl.sv
// DS1302 sequencer: clears write-protect, polls the 7 time registers, services set-time writes.
// One driver transaction at a time over an en/busy handshake; every handshake phase is bounded by a timeout.
module ds1302_ctrl #(
    parameter int CLK_FRE     = 50,
    parameter int POLL_MS     = 100,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_req,
    input  logic [55:0] set_time,
    output logic        set_done,
    output logic [55:0] time_out,
    output logic        time_valid,
    output logic        init_done,
    output logic        err,
    output logic [7:0]  drv_addr,
    output logic [7:0]  drv_wdata,
    output logic        drv_en,
    input  logic        drv_busy,
    input  logic [7:0]  drv_rdata
);

    localparam logic [31:0] POLL_TC = 32'(POLL_MS * CLK_FRE * 1000 - 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_TC = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {WP_OFF, POLL_WAIT, RD_BURST, WR_BURST} state_t;
    typedef enum logic [1:0] {PH_LOAD, PH_ISSUE, PH_WAIT} phase_t;

    state_t          state, state_nx;
    phase_t          phase, phase_nx;
    logic [2:0]      idx, idx_nx;
    logic [31:0]     poll_cnt, poll_nx;
    logic [TO_W-1:0] ph_cnt, ph_cnt_nx;
    logic            pend, pend_nx, pend_new, pend_new_nx;
    logic [55:0]     pend_time, pend_time_nx, wr_buf, wr_buf_nx, rd_buf, rd_buf_nx;
    logic [55:0]     time_out_nx;
    logic            time_valid_nx, set_done_nx, err_nx, init_done_nx, en_nx;
    logic [7:0]      addr_nx, wdata_nx, cmd_addr, cmd_wdata;
    logic            txn_done, txn_abort;

    // Command byte for the transaction at (state, idx); reads use the odd addresses.
    always_comb begin
        cmd_addr  = 8'h8E;
        cmd_wdata = 8'h00;
        case (state)
            RD_BURST: cmd_addr = {4'b1000, idx, 1'b1};
            WR_BURST: begin
                cmd_addr  = {4'b1000, idx, 1'b0};
                cmd_wdata = (idx == 3'd0) ? {1'b0, wr_buf[6:0]} : wr_buf[8*idx +: 8];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx      = state;
        phase_nx      = phase;
        idx_nx        = idx;
        poll_nx       = poll_cnt;
        ph_cnt_nx     = ph_cnt;
        pend_nx       = pend;
        pend_new_nx   = pend_new;
        pend_time_nx  = pend_time;
        wr_buf_nx     = wr_buf;
        rd_buf_nx     = rd_buf;
        time_out_nx   = time_out;
        time_valid_nx = 1'b0;
        set_done_nx   = 1'b0;
        err_nx        = 1'b0;
        init_done_nx  = init_done;
        addr_nx       = drv_addr;
        wdata_nx      = drv_wdata;
        en_nx         = drv_en;
        txn_done      = 1'b0;
        txn_abort     = 1'b0;

        if (set_req) begin
            pend_nx      = 1'b1;
            pend_time_nx = set_time;
            if (state == WR_BURST)
                pend_new_nx = 1'b1;
        end

        case (state)
            POLL_WAIT: begin
                poll_nx = poll_cnt + 32'd1;
                // A request arriving in the entry cycle is merged into this burst (latest wins).
                if (init_done && pend) begin
                    state_nx  = WR_BURST;
                    phase_nx  = PH_LOAD;
                    idx_nx    = 3'd0;
                    wr_buf_nx = set_req ? set_time : pend_time;
                end else if (poll_cnt == POLL_TC) begin
                    state_nx = init_done ? RD_BURST : WP_OFF;
                    phase_nx = PH_LOAD;
                    idx_nx   = 3'd0;
                end
            end
            default: begin
                case (phase)
                    PH_LOAD: begin
                        en_nx     = 1'b1;
                        addr_nx   = cmd_addr;
                        wdata_nx  = cmd_wdata;
                        phase_nx  = PH_ISSUE;
                        ph_cnt_nx = '0;
                    end
                    PH_ISSUE: begin
                        if (drv_busy) begin
                            en_nx     = 1'b0;
                            phase_nx  = PH_WAIT;
                            ph_cnt_nx = '0;
                        end else if (ph_cnt == TO_TC) begin
                            txn_abort = 1'b1;
                        end else begin
                            ph_cnt_nx = ph_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (!drv_busy)
                            txn_done = 1'b1;
                        else if (ph_cnt == TO_TC)
                            txn_abort = 1'b1;
                        else
                            ph_cnt_nx = ph_cnt + 1'b1;
                    end
                endcase

                if (txn_abort) begin
                    err_nx      = 1'b1;
                    en_nx       = 1'b0;
                    state_nx    = POLL_WAIT;
                    poll_nx     = '0;
                    pend_new_nx = 1'b0;
                end else if (txn_done) begin
                    phase_nx  = PH_LOAD;
                    idx_nx    = idx + 3'd1;
                    ph_cnt_nx = '0;
                    if (state == RD_BURST)
                        rd_buf_nx[8*idx +: 8] = (idx == 3'd0) ? (drv_rdata & 8'h7F) : drv_rdata;
                    if (state == WP_OFF || idx == 3'd6) begin
                        state_nx = POLL_WAIT;
                        poll_nx  = '0;
                        case (state)
                            WP_OFF:   init_done_nx = 1'b1;
                            RD_BURST: begin
                                time_out_nx   = {drv_rdata, rd_buf[47:0]};
                                time_valid_nx = 1'b1;
                            end
                            default: begin
                                set_done_nx = 1'b1;
                                pend_nx     = set_req | pend_new;
                                pend_new_nx = 1'b0;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WP_OFF;
            phase      <= PH_LOAD;
            idx        <= '0;
            poll_cnt   <= '0;
            ph_cnt     <= '0;
            pend       <= 1'b0;
            pend_new   <= 1'b0;
            pend_time  <= '0;
            wr_buf     <= '0;
            rd_buf     <= '0;
            time_out   <= '0;
            time_valid <= 1'b0;
            set_done   <= 1'b0;
            err        <= 1'b0;
            init_done  <= 1'b0;
            drv_addr   <= '0;
            drv_wdata  <= '0;
            drv_en     <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            idx        <= idx_nx;
            poll_cnt   <= poll_nx;
            ph_cnt     <= ph_cnt_nx;
            pend       <= pend_nx;
            pend_new   <= pend_new_nx;
            pend_time  <= pend_time_nx;
            wr_buf     <= wr_buf_nx;
            rd_buf     <= rd_buf_nx;
            time_out   <= time_out_nx;
            time_valid <= time_valid_nx;
            set_done   <= set_done_nx;
            err        <= err_nx;
            init_done  <= init_done_nx;
            drv_addr   <= addr_nx;
            drv_wdata  <= wdata_nx;
            drv_en     <= en_nx;
        end
    end

endmodule

// File: tb/tb_ds1302_ctrl.sv
// Bench for ds1302_ctrl: DS1302 driver model with a register array, read/write/timeout/reset sequences.
module tb_ds1302_ctrl;

    localparam int CLK_FRE = 1, POLL_MS = 1, TIMEOUT_CYC = 200;

    logic        clk = 1'b0;
    logic        rst_n, set_req, set_done, time_valid, init_done, err;
    logic [55:0] set_time, time_out;
    logic [7:0]  drv_addr, drv_wdata, drv_rdata;
    logic        drv_en, drv_busy;

    always #5 clk = ~clk;

    ds1302_ctrl #(.CLK_FRE(CLK_FRE), .POLL_MS(POLL_MS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .set_time(set_time),
        .set_done(set_done), .time_out(time_out), .time_valid(time_valid),
        .init_done(init_done), .err(err), .drv_addr(drv_addr), .drv_wdata(drv_wdata),
        .drv_en(drv_en), .drv_busy(drv_busy), .drv_rdata(drv_rdata)
    );

    int n_chk = 0, n_fail = 0;
    int n_valid = 0, n_done = 0, n_err = 0, cyc = 0, err_cyc = 0;
    logic err_en = 1'b1;
    logic no_busy = 1'b0;
    logic [15:0] txn_log[$];
    logic [7:0]  rtc[8];

    typedef struct {
        logic [55:0] rtc;
        logic [55:0] exp;
    } tv_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] log_at(input int k);
        if (k < txn_log.size()) return txn_log[k];
        return 16'hFFFF;
    endfunction

    function automatic int cnt_of(input int sel);
        case (sel)
            0: return n_valid;
            1: return n_done;
            2: return n_err;
            3: return txn_log.size();
            4: return int'(init_done);
            5: return int'(drv_en && drv_addr == 8'h85);
            default: return int'(drv_en);
        endcase
    endfunction

    task automatic wait_until(input int sel, input int target, input int budget, input string name);
        int c = 0;
        while (cnt_of(sel) < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, 64'(cnt_of(sel) >= target), 64'(1));
    endtask

    task automatic set_rtc(input logic [55:0] v);
        for (int i = 0; i < 7; i++) rtc[i] = v[8*i +: 8];
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (time_valid) n_valid++;
        if (set_done) n_done++;
        if (err) begin
            n_err++;
            err_cyc = cyc;
            err_en  = drv_en;
        end
    end

    // Driver model: raises busy 3 cycles after seeing en, holds it a random time, then completes.
    initial begin
        int st;
        int cnt;
        logic [7:0] ca, cw;
        st = 0; cnt = 0; ca = '0; cw = '0;
        drv_busy = 1'b0;
        drv_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                drv_busy = 1'b0;
                st = 0;
            end else begin
                case (st)
                    0: if (drv_en && !no_busy) begin
                        ca = drv_addr; cw = drv_wdata; cnt = 3; st = 1;
                    end
                    1: if (cnt <= 1) begin
                        drv_busy = 1'b1; cnt = $urandom_range(2, 6); st = 2;
                    end else cnt--;
                    default: if (cnt <= 1) begin
                        chk("addr_stable", 64'({drv_addr, drv_wdata}), 64'({ca, cw}));
                        if (ca[0]) drv_rdata = rtc[ca[3:1]];
                        else rtc[ca[3:1]] = cw;
                        txn_log.push_back({ca, cw});
                        drv_busy = 1'b0;
                        st = 0;
                    end else cnt--;
                endcase
            end
        end
    end

    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        tv_t tbl[4];
        logic [55:0] va, vb, w;
        logic [15:0] e;
        int v0, e0, d0, c0, dt;

        tbl[0].rtc = 56'h24_03_06_15_12_30_D9; tbl[0].exp = 56'h24_03_06_15_12_30_59;
        tbl[1].rtc = 56'h99_07_12_31_23_59_59; tbl[1].exp = 56'h99_07_12_31_23_59_59;
        tbl[2].rtc = 56'h00_01_01_01_00_00_80; tbl[2].exp = 56'h00_01_01_01_00_00_00;
        tbl[3].rtc = 56'hFF_FF_FF_FF_FF_FF_FF; tbl[3].exp = 56'hFF_FF_FF_FF_FF_FF_7F;

        rst_n = 1'b0; set_req = 1'b0; set_time = '0;
        rtc[7] = 8'h80;
        set_rtc(tbl[0].rtc);
        repeat (3) @(negedge clk);
        chk("rst_time_out", 64'(time_out), 64'(0));
        chk("rst_flags", 64'({time_valid, set_done, err, init_done, drv_en}), 64'(0));
        chk("rst_drv_bus", 64'({drv_addr, drv_wdata}), 64'(0));
        rst_n = 1'b1;

        // Write-protect clear comes first, then a read burst one poll interval later.
        wait_until(3, 1, 200, "wp_txn_wait");
        chk("wp_txn", 64'(log_at(0)), 64'(16'h8E00));
        wait_until(4, 1, 10, "init_done_wait");
        txn_log.delete();
        wait_until(0, 1, 3000, "first_valid_wait");
        for (int k = 0; k < 7; k++)
            chk("rd_order", 64'(log_at(k) >> 8), 64'(8'h81 + 2 * k));
        chk("tv_first", 64'(time_out), 64'(tbl[0].exp));
        repeat (5) @(negedge clk);
        chk("tv_once", 64'(n_valid), 64'(1));

        for (int i = 1; i < 4; i++) begin
            v0 = n_valid;
            set_rtc(tbl[i].rtc);
            wait_until(0, v0 + 1, 3000, "tbl_wait");
            chk("tbl_time", 64'(time_out), 64'(tbl[i].exp));
        end

        for (int i = 0; i < 4; i++) begin
            va[31:0]  = $urandom();
            va[55:32] = 24'($urandom());
            v0 = n_valid;
            set_rtc(va);
            wait_until(0, v0 + 1, 3000, "rand_wait");
            chk("rand_time", 64'(time_out), 64'(va & ~56'h80));
        end

        // Set request during the third read: read burst completes, then the write burst.
        wait_until(5, 1, 3000, "rd3_wait");
        v0 = n_valid; d0 = n_done;
        set_time = 56'h25_01_01_01_00_00_80;
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        wait_until(0, v0 + 1, 500, "rd_finish_wait");
        chk("no_done_before_rd", 64'(n_done), 64'(d0));
        txn_log.delete();
        wait_until(1, d0 + 1, 500, "wr_done_wait");
        w = 56'h25_01_01_01_00_00_00;
        chk("wr_count", 64'(txn_log.size()), 64'(7));
        for (int k = 0; k < 7; k++) begin
            e = {8'(8'h80 + 2 * k), w[8*k +: 8]};
            chk("wr_txn", 64'(log_at(k)), 64'(e));
        end
        repeat (3) @(negedge clk);
        chk("done_once", 64'(n_done), 64'(d0 + 1));
        v0 = n_valid;
        wait_until(0, v0 + 1, 3000, "readback_wait");
        chk("readback_set", 64'(time_out), 64'(w));

        // Back-to-back set requests: one burst carrying the later value.
        d0 = n_done; v0 = n_valid;
        txn_log.delete();
        va = 56'h11_02_03_04_05_06_07;
        vb = 56'h26_05_11_28_09_45_B3;
        set_time = va; set_req = 1'b1;
        @(negedge clk);
        set_time = vb;
        @(negedge clk);
        set_req = 1'b0;
        wait_until(1, d0 + 1, 500, "dbl_done_wait");
        wait_until(0, v0 + 1, 3000, "dbl_read_wait");
        chk("dbl_txn_count", 64'(txn_log.size()), 64'(14));
        for (int k = 0; k < 7; k++) begin
            e = {8'(8'h80 + 2 * k), (k == 0) ? (vb[7:0] & 8'h7F) : vb[8*k +: 8]};
            chk("dbl_wr_txn", 64'(log_at(k)), 64'(e));
        end
        chk("dbl_done_once", 64'(n_done), 64'(d0 + 1));
        chk("dbl_readback", 64'(time_out), 64'(vb & ~56'h80));

        // Driver never answers: abort with err, no time_valid, retry after the poll interval.
        v0 = n_valid; e0 = n_err;
        no_busy = 1'b1;
        wait_until(2, e0 + 1, 1500, "err_wait");
        chk("err_en_low", 64'(err_en), 64'(0));
        chk("no_valid_on_abort", 64'(n_valid), 64'(v0));
        c0 = err_cyc;
        no_busy = 1'b0;
        @(negedge clk);
        wait_until(6, 1, 1500, "retry_wait");
        dt = cyc - c0;
        chk("retry_gap", 64'(dt >= 1000 && dt <= 1002), 64'(1));
        wait_until(0, v0 + 1, 500, "retry_valid_wait");
        chk("err_once", 64'(n_err), 64'(e0 + 1));

        // Reset mid-read drops drv_en at once and restarts at write-protect clear.
        wait_until(6, 1, 3000, "rd_en_wait");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_en", 64'(drv_en), 64'(0));
        chk("rst_mid_state", 64'({init_done, time_out}), 64'(0));
        repeat (3) @(negedge clk);
        txn_log.delete();
        rst_n = 1'b1;
        wait_until(3, 1, 200, "wp_again_wait");
        chk("wp_again", 64'(log_at(0)), 64'(16'h8E00));
        wait_until(4, 1, 10, "init_again_wait");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
